// File: rtl/riscv_pkg.sv
// Shared constants for the data-memory path: router FSM encoding,
// target select codes and the default memory map.
package riscv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] TGT_RAM  = 2'd0;
    localparam logic [1:0] TGT_IO   = 2'd1;
    localparam logic [1:0] TGT_NONE = 2'd2;

    localparam logic [31:0] DEF_RAM_BASE = 32'h0000_0000;
    localparam int          DEF_RAM_AW   = 12;
    localparam logic [31:0] DEF_IO_BASE  = 32'h1000_0000;
    localparam int          DEF_IO_AW    = 8;
    localparam int          DEF_TIMEOUT  = 15;

endpackage

// File: rtl/addr_decode.sv
// Maps a byte address onto the RAM window, the peripheral window or nothing.
// RAM is checked first so it wins if the windows were ever made to overlap.
module addr_decode
    import riscv_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter int          RAM_AW   = DEF_RAM_AW,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE,
    parameter int          IO_AW    = DEF_IO_AW
) (
    input  logic [31:0] addr,
    output logic [1:0]  tgt
);

    logic unused_addr;
    assign unused_addr = ^addr;

    always_comb begin
        tgt = TGT_NONE;
        if (addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]) begin
            tgt = TGT_RAM;
        end else if (addr[31:IO_AW] == IO_BASE[31:IO_AW]) begin
            tgt = TGT_IO;
        end
    end

endmodule

// File: rtl/dmem_router.sv
// Steers one outstanding data-memory transaction to RAM or peripheral space
// and returns its response, covering unmapped addresses and timeouts.
module dmem_router
    import riscv_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter int          RAM_AW   = DEF_RAM_AW,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE,
    parameter int          IO_AW    = DEF_IO_AW,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_valid,
    input  logic        ram_ready,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic [3:0]  ram_wstrb,
    input  logic        ram_rvalid,
    input  logic [31:0] ram_rdata,
    output logic        io_valid,
    input  logic        io_ready,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        io_we,
    output logic [3:0]  io_wstrb,
    input  logic        io_rvalid,
    input  logic [31:0] io_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [1:0]  dec_tgt;
    logic        sel_ready;
    logic        sel_rvalid;
    logic [31:0] sel_rdata;
    logic        tmo;

    addr_decode #(
        .RAM_BASE (RAM_BASE),
        .RAM_AW   (RAM_AW),
        .IO_BASE  (IO_BASE),
        .IO_AW    (IO_AW)
    ) u_decode (
        .addr (req_addr),
        .tgt  (dec_tgt)
    );

    assign sel_ready  = (tgt_q == TGT_RAM) ? ram_ready  : io_ready;
    assign sel_rvalid = (tgt_q == TGT_RAM) ? ram_rvalid : io_rvalid;
    assign sel_rdata  = (tgt_q == TGT_RAM) ? ram_rdata  : io_rdata;

    // Fires on the last REQ/WAIT cycle, so DONE lands TIMEOUT+1 after accept
    assign tmo = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    tgt_d   = dec_tgt;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = (dec_tgt == TGT_NONE);
                    state_d = (dec_tgt == TGT_NONE) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else if (sel_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (sel_rvalid) begin
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= TGT_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_err   = resp_valid & err_q;

    assign ram_valid = (state_q == ST_REQ) && (tgt_q == TGT_RAM);
    assign io_valid  = (state_q == ST_REQ) && (tgt_q == TGT_IO);

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;
    assign ram_wstrb = wstrb_q;
    assign io_addr   = addr_q;
    assign io_wdata  = wdata_q;
    assign io_we     = we_q;
    assign io_wstrb  = wstrb_q;

endmodule

// File: tb/tb_dmem_router.sv
// Directed bench for dmem_router: a table of single transactions against a
// reactive target model, plus sequences for timeout, reset and back-to-back.
module tb_dmem_router;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_valid, ram_ready, ram_we, ram_rvalid;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_wstrb;
    logic        io_valid, io_ready, io_we, io_rvalid;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic [3:0]  io_wstrb;

    always #5 clk = ~clk;

    dmem_router dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_valid  (ram_valid),
        .ram_ready  (ram_ready),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_wstrb  (ram_wstrb),
        .ram_rvalid (ram_rvalid),
        .ram_rdata  (ram_rdata),
        .io_valid   (io_valid),
        .io_ready   (io_ready),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_we      (io_we),
        .io_wstrb   (io_wstrb),
        .io_rvalid  (io_rvalid),
        .io_rdata   (io_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  tgt;
        int          rdy_dly;
        int          rv_dly;
        logic [31:0] trdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV    = 10;
    localparam int NEVER = 99;
    localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

    vec_t vecs[NV];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_targets();
        ram_ready  = 1'b0;
        ram_rvalid = 1'b0;
        ram_rdata  = JUNK;
        io_ready   = 1'b0;
        io_rvalid  = 1'b0;
        io_rdata   = JUNK;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  lat, wcnt, hs_c;
        bit  hs, xbad, fbad;
        logic [31:0] rd;
        logic        er;
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFF0;
        req_wdata = JUNK;
        lat = 0; wcnt = 0; hs = 0; hs_c = 0; xbad = 0; fbad = 0;
        rd = 'x; er = 'x;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
            end
            if (ram_valid && v.tgt != TGT_RAM) xbad = 1;
            if (io_valid && v.tgt != TGT_IO) xbad = 1;
            if (ram_valid && (ram_addr != v.addr || ram_we != v.we ||
                ram_wdata != v.wdata || ram_wstrb != v.wstrb)) fbad = 1;
            if (io_valid && (io_addr != v.addr || io_we != v.we ||
                io_wdata != v.wdata || io_wstrb != v.wstrb)) fbad = 1;
            idle_targets();
            if (hs && v.rv_dly != NEVER && c == hs_c + 1 + v.rv_dly) begin
                if (v.tgt == TGT_RAM) begin
                    ram_rvalid = 1'b1;
                    ram_rdata  = v.trdata;
                end else begin
                    io_rvalid = 1'b1;
                    io_rdata  = v.trdata;
                end
            end
            if (!hs && (ram_valid || io_valid)) begin
                if (v.rdy_dly != NEVER && wcnt >= v.rdy_dly) begin
                    if (v.tgt == TGT_RAM) ram_ready = 1'b1;
                    else io_ready = 1'b1;
                    hs   = 1;
                    hs_c = c;
                end
                wcnt++;
            end
            if (lat == 0) begin
                @(posedge clk); #1;
            end
        end
        idle_targets();
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d rdata", idx), rd, v.rdata);
        chk($sformatf("v%0d err", idx), {31'b0, er}, {31'b0, v.err});
        chk($sformatf("v%0d wrong target valid", idx), {31'b0, xbad}, 0);
        chk($sformatf("v%0d target fields", idx), {31'b0, fbad}, 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d resp pulse width", idx), {31'b0, resp_valid}, 0);
        chk($sformatf("v%0d ready after done", idx), {31'b0, req_ready}, 1);
    endtask

    initial begin
        logic [31:0] r1d, r2d;
        int  r1c, r2c, nresp, acc2;
        bit  bad, hs_r, hs_i, early;

        vecs[0] = '{32'h0000_0010, 1'b0, 32'h0, 4'h0, TGT_RAM,
                    0, 0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{32'h1000_0004, 1'b1, 32'h0000_0055, 4'b0001, TGT_IO,
                    3, 0, 32'h0000_1234, 6, 32'h0, 1'b0};
        vecs[2] = '{32'h2000_0000, 1'b0, 32'h0, 4'h0, TGT_NONE,
                    0, 0, 32'h0, 1, 32'h0, 1'b1};
        vecs[3] = '{32'h0000_0FFC, 1'b0, 32'h0, 4'hF, TGT_RAM,
                    1, 2, 32'hCAFE_F00D, 6, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'h0000_1000, 1'b0, 32'h0, 4'h0, TGT_NONE,
                    0, 0, 32'h0, 1, 32'h0, 1'b1};
        vecs[5] = '{32'h1000_00FF, 1'b0, 32'h0, 4'h0, TGT_IO,
                    0, 1, 32'h89AB_CDEF, 4, 32'h89AB_CDEF, 1'b0};
        vecs[6] = '{32'h1000_0100, 1'b1, 32'h1, 4'h1, TGT_NONE,
                    0, 0, 32'h0, 1, 32'h0, 1'b1};
        vecs[7] = '{32'h0000_0020, 1'b0, 32'h0, 4'h0, TGT_RAM,
                    NEVER, NEVER, 32'h0, 16, 32'h0, 1'b1};
        vecs[8] = '{32'h1000_0010, 1'b0, 32'h0, 4'h0, TGT_IO,
                    0, NEVER, 32'h0, 16, 32'h0, 1'b1};
        vecs[9] = '{32'h0000_0300, 1'b1, 32'hA1B2_C3D4, 4'b1100, TGT_RAM,
                    0, 0, 32'hFFFF_FFFF, 3, 32'h0, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_we    = 1'b0;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        idle_targets();
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", {31'b0, req_ready}, 1);
        chk("reset resp_valid", {31'b0, resp_valid}, 0);
        chk("reset resp_rdata", resp_rdata, 0);
        chk("reset resp_err", {31'b0, resp_err}, 0);
        chk("reset target valids", {30'b0, ram_valid, io_valid}, 0);
        chk("reset latched addr", ram_addr, 0);
        chk("reset latched wdata", io_wdata, 0);
        chk("reset latched wstrb", {28'b0, ram_wstrb}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Late response after a timeout must vanish
        run_vec(vecs[7], 100);
        ram_rvalid = 1'b1;
        ram_rdata  = 32'h1111_1111;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            ram_rvalid = 1'b0;
            if (resp_valid || !req_ready) bad = 1;
        end
        chk("late rvalid ignored", {31'b0, bad}, 0);
        run_vec('{32'h0000_0044, 1'b0, 32'h0, 4'h0, TGT_RAM,
                  0, 0, 32'h2222_3333, 3, 32'h2222_3333, 1'b0}, 101);

        // Reset while waiting for the RAM response
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        req_we    = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ram_ready = 1'b1;
        @(posedge clk); #1;
        ram_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst-wait req_ready", {31'b0, req_ready}, 1);
        chk("rst-wait ram_valid", {31'b0, ram_valid}, 0);
        chk("rst-wait resp_valid", {31'b0, resp_valid}, 0);
        chk("rst-wait latched addr", ram_addr, 0);
        ram_rvalid = 1'b1;
        ram_rdata  = 32'h0000_0077;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            ram_rvalid = 1'b0;
            if (resp_valid) bad = 1;
        end
        chk("rst-wait stale rvalid", {31'b0, bad}, 0);

        // Back-to-back: RAM then IO with req_valid held high
        req_valid = 1'b1;
        req_addr  = 32'h0000_0020;
        req_we    = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h1000_0008;
        hs_r = 0; hs_i = 0; early = 0;
        nresp = 0; acc2 = 0; r1c = 0; r2c = 0; r1d = 'x; r2d = 'x;
        for (int c = 1; c <= 12; c++) begin
            ram_rvalid = hs_r;
            ram_rdata  = hs_r ? 32'hA5A5_0001 : JUNK;
            io_rvalid  = hs_i;
            io_rdata   = hs_i ? 32'h0000_00B2 : JUNK;
            ram_ready  = ram_valid;
            io_ready   = io_valid;
            hs_r = ram_valid;
            hs_i = io_valid;
            if (resp_valid) begin
                if (nresp == 0) begin r1c = c; r1d = resp_rdata; end
                else begin r2c = c; r2d = resp_rdata; end
                nresp++;
            end
            if (req_ready && c < 4) early = 1;
            if (req_ready && req_valid && acc2 == 0) acc2 = c;
            @(posedge clk); #1;
            if (acc2 != 0) req_valid = 1'b0;
        end
        idle_targets();
        chk("b2b no early ready", {31'b0, early}, 0);
        chk("b2b second accept cycle", acc2, 4);
        chk("b2b response count", nresp, 2);
        chk("b2b resp1 cycle", r1c, 3);
        chk("b2b resp1 data", r1d, 32'hA5A5_0001);
        chk("b2b resp2 cycle", r2c, 7);
        chk("b2b resp2 data", r2d, 32'h0000_00B2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
